motor_ramp_sequencer: RTL and testbench
=======================================

// Module: motor_ramp_sequencer
// PURPOSE
//  Sequences the motor PWM datapath: slews the commanded duty cycle toward the
//  requested value at a bounded rate, and enforces a zero-duty dead time
//  before any direction reversal. Also latches faults and forces the bridge off.
//  Sits between the host/command interface and the PWM generator / bridge driver.
// PARAMETERS
//  DUTY_W    10    width of duty words (0 .. 2**DUTY_W-1)
//  STEP_DIV  1000  clocks per ramp tick (>=1)
//  RAMP_STEP 1     duty change per ramp tick (>=1, < 2**DUTY_W)
//  DEAD_CYC  500   clocks at zero duty before dir_out may change (>=1)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous reset, active-low
//  en         in   1       run request; 0 = ramp down to zero duty
//  dir_req    in   1       requested direction (0 fwd, 1 rev)
//  duty_req   in   DUTY_W  requested duty, sampled every clock
//  fault      in   1       bridge fault, level, synchronous to clk
//  fault_clr  in   1       one-cycle pulse, clears a latched fault
//  duty_out   out  DUTY_W  duty to the PWM generator
//  dir_out    out  1       direction to the commutation logic
//  pwm_en     out  1       bridge output enable
//  state_out  out  3       current state encoding (debug/status)
//  busy       out  1       1 while duty_out != target or in DEAD
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, duty_out=0, dir_out=0, pwm_en=0,
//   busy=0, tick counter=0, dead counter=0. Outputs are registered.
//  Tick: free-running counter 0..STEP_DIV-1; tick=1 on the cycle it wraps.
//   Counter restarts at 0 on entry to RAMP.
//  Target: 0 if !en or dir_req!=dir_out, else duty_req.
//  States (state_out): IDLE=0 RAMP=1 RUN=2 DEAD=3 FAULT=4.
//   IDLE:  pwm_en=0, duty_out=0. en=1 and dir_req==dir_out -> RAMP;
//          en=1 and dir_req!=dir_out -> DEAD.
//   RAMP:  pwm_en=1. On tick: duty_out moves toward target by RAMP_STEP,
//          saturating exactly at target (no overshoot, no wrap). When
//          duty_out==target: target!=0 -> RUN; target==0 and
//          dir_req!=dir_out -> DEAD; target==0 otherwise -> IDLE.
//   RUN:   duty_out held. target!=duty_out -> RAMP (next cycle).
//   DEAD:  pwm_en=0, duty_out=0; count DEAD_CYC clocks, then
//          dir_out<=dir_req and -> RAMP if en, else IDLE. dir_req
//          toggling back during DEAD does not shorten the count.
//   FAULT: entered from any state the cycle after fault=1; that same edge
//          sets duty_out=0, pwm_en=0. dir_out kept. Exit to IDLE only when
//          fault_clr=1, fault=0 and en=0 on the same clock; otherwise stay.
//  Priority: fault > direction change > duty target change.
//  duty_req changes during RAMP retarget immediately; ramp direction
//   reverses on the next tick without stopping.
//  busy = (state==RAMP) | (state==DEAD).
//  Reset mid-ramp: outputs go to reset values immediately, no ramp-down.
// TESTING (bench params: DUTY_W=8, STEP_DIV=4, RAMP_STEP=3, DEAD_CYC=8)
//  1 rst release, en=1, duty_req=10 -> duty_out 3,6,9,10 every 4 clk,
//    then state_out=2, busy=0, pwm_en=1.
//  2 In RUN at 10, en=0 -> duty_out 7,4,1,0 per tick, then state IDLE,
//    pwm_en=0.
//  3 In RUN at 10, dir_req 0->1 -> ramp to 0, DEAD for 8 clk with pwm_en=0,
//    dir_out=1, ramp back to 10 with dir_out=1 throughout.
//  4 fault=1 mid-ramp -> next edge duty_out=0, pwm_en=0, state 4; fault_clr
//    with en=1 ignored; fault_clr with en=0, fault=0 -> IDLE.
//  5 duty_req=255 then 250 mid-ramp -> saturates at 255 never wraps, then
//    ramps down to exactly 250; rst=0 mid-ramp -> all outputs 0 async.

Source files
------------

// File: rtl/motor_ramp_sequencer.sv
// Motor ramp sequencer: slews the PWM duty toward the requested value at a
// bounded rate, holds zero duty for a dead time before any direction
// reversal, and latches bridge faults with the bridge forced off.
module motor_ramp_sequencer #(
  parameter int DUTY_W    = 10,
  parameter int STEP_DIV  = 1000,
  parameter int RAMP_STEP = 1,
  parameter int DEAD_CYC  = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir_req,
  input  logic [DUTY_W-1:0] duty_req,
  input  logic              fault,
  input  logic              fault_clr,
  output logic [DUTY_W-1:0] duty_out,
  output logic              dir_out,
  output logic              pwm_en,
  output logic [2:0]        state_out,
  output logic              busy
);

  localparam int TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);
  localparam logic [DUTY_W:0]   STEP_EXT  = (DUTY_W + 1)'(RAMP_STEP);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DEAD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic                dir_q, dir_d;
  logic                pwm_en_q, pwm_en_d;
  logic                busy_q, busy_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
  logic [DUTY_W-1:0]   target;
  logic                tick;

  // One ramp step from cur toward tgt, clamped so it lands exactly on tgt.
  // Arithmetic is one bit wider so neither direction can wrap.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt
  );
    logic [DUTY_W:0] cur_x;
    logic [DUTY_W:0] tgt_x;
    cur_x = {1'b0, cur};
    tgt_x = {1'b0, tgt};
    if (tgt_x > cur_x) begin
      if ((tgt_x - cur_x) > STEP_EXT) step_toward = DUTY_W'(cur_x + STEP_EXT);
      else                            step_toward = tgt;
    end else if (cur_x > tgt_x) begin
      if ((cur_x - tgt_x) > STEP_EXT) step_toward = DUTY_W'(cur_x - STEP_EXT);
      else                            step_toward = tgt;
    end else begin
      step_toward = cur;
    end
  endfunction

  // Next-state, duty, direction, counters and registered output enables.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    dead_cnt_d = '0;
    target     = (!en || (dir_req != dir_q)) ? '0 : duty_req;
    tick       = (tick_cnt_q == TICK_LAST);

    if (fault) begin
      state_d = ST_FAULT;
      duty_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_d = '0;
          if (en) state_d = (dir_req != dir_q) ? ST_DEAD : ST_RAMP;
        end
        ST_RAMP: begin
          if (duty_q == target) begin
            if (target != '0)         state_d = ST_RUN;
            else if (dir_req != dir_q) state_d = ST_DEAD;
            else                       state_d = ST_IDLE;
          end else if (tick) begin
            duty_d = step_toward(duty_q, target);
          end
        end
        ST_RUN: begin
          if (target != duty_q) state_d = ST_RAMP;
        end
        ST_DEAD: begin
          // The count always runs to completion; dir_req is only sampled at the end.
          duty_d = '0;
          if (dead_cnt_q == DEAD_LAST) begin
            dir_d   = dir_req;
            state_d = en ? ST_RAMP : ST_IDLE;
          end else begin
            dead_cnt_d = dead_cnt_q + 1'b1;
          end
        end
        ST_FAULT: begin
          duty_d = '0;
          if (fault_clr && !en) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
        end
      endcase
    end

    // Tick phase restarts on RAMP entry so the first step is a full period away.
    if ((state_d == ST_RAMP) && (state_q != ST_RAMP)) tick_cnt_d = '0;
    else if (tick)                                      tick_cnt_d = '0;
    else                                                tick_cnt_d = tick_cnt_q + 1'b1;

    pwm_en_d = (state_d == ST_RAMP) || (state_d == ST_RUN);
    busy_d   = (state_d == ST_RAMP) || (state_d == ST_DEAD);
  end

  // State and output registers; reset forces the bridge off immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      duty_q     <= '0;
      dir_q      <= 1'b0;
      pwm_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      tick_cnt_q <= '0;
      dead_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      pwm_en_q   <= pwm_en_d;
      busy_q     <= busy_d;
      tick_cnt_q <= tick_cnt_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

  assign duty_out  = duty_q;
  assign dir_out   = dir_q;
  assign pwm_en    = pwm_en_q;
  assign state_out = state_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Bench for motor_ramp_sequencer: directed scenarios plus randomized inputs,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_motor_ramp_sequencer;

  localparam int DUTY_W    = 8;
  localparam int STEP_DIV  = 4;
  localparam int RAMP_STEP = 3;
  localparam int DEAD_CYC  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              dir_req;
  logic [DUTY_W-1:0] duty_req;
  logic              fault;
  logic              fault_clr;
  logic [DUTY_W-1:0] duty_out;
  logic              dir_out;
  logic              pwm_en;
  logic [2:0]        state_out;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: mode uses the published state codes 0..4.
  int m_mode, m_duty, m_dir, m_phase, m_dead_left;

  motor_ramp_sequencer #(
    .DUTY_W(DUTY_W), .STEP_DIV(STEP_DIV), .RAMP_STEP(RAMP_STEP), .DEAD_CYC(DEAD_CYC)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .dir_req(dir_req), .duty_req(duty_req),
    .fault(fault), .fault_clr(fault_clr), .duty_out(duty_out), .dir_out(dir_out),
    .pwm_en(pwm_en), .state_out(state_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_duty = 0; m_dir = 0; m_phase = 0; m_dead_left = 0;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_clock();
    int tgt, nmode, nduty, ndir, gap;
    tgt   = (en && (int'(dir_req) == m_dir)) ? int'(duty_req) : 0;
    nmode = m_mode; nduty = m_duty; ndir = m_dir;
    if (fault) begin
      nmode = 4; nduty = 0;
    end else begin
      case (m_mode)
        0: begin
          nduty = 0;
          if (en) nmode = (int'(dir_req) != m_dir) ? 3 : 1;
        end
        1: begin
          if (m_duty == tgt) nmode = (tgt != 0) ? 2 : ((int'(dir_req) != m_dir) ? 3 : 0);
          else if (m_phase == STEP_DIV - 1) begin
            gap = tgt - m_duty;
            if (gap > RAMP_STEP)  gap = RAMP_STEP;
            if (gap < -RAMP_STEP) gap = -RAMP_STEP;
            nduty = m_duty + gap;
          end
        end
        2: if (tgt != m_duty) nmode = 1;
        3: begin
          nduty = 0;
          m_dead_left--;
          if (m_dead_left == 0) begin
            ndir  = int'(dir_req);
            nmode = en ? 1 : 0;
          end
        end
        default: if (fault_clr && !en) nmode = 0;
      endcase
    end
    if (nmode == 3 && m_mode != 3) m_dead_left = DEAD_CYC;
    m_phase = (nmode == 1 && m_mode != 1) ? 0 : (m_phase + 1) % STEP_DIV;
    m_mode = nmode; m_duty = nduty; m_dir = ndir;
  endfunction

  task automatic compare_model(input string tag);
    check_eq({tag, ".duty"},  int'(duty_out),  m_duty);
    check_eq({tag, ".dir"},   int'(dir_out),   m_dir);
    check_eq({tag, ".pwm"},   int'(pwm_en),    (m_mode == 1 || m_mode == 2) ? 1 : 0);
    check_eq({tag, ".state"}, int'(state_out), m_mode);
    check_eq({tag, ".busy"},  int'(busy),      (m_mode == 1 || m_mode == 3) ? 1 : 0);
  endtask

  task automatic cycle(input string tag);
    model_clock();
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".duty"},  int'(duty_out),  0);
    check_eq({tag, ".dir"},   int'(dir_out),   0);
    check_eq({tag, ".pwm"},   int'(pwm_en),    0);
    check_eq({tag, ".state"}, int'(state_out), 0);
    check_eq({tag, ".busy"},  int'(busy),      0);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; dir_req = 1'b0; duty_req = '0; fault = 1'b0; fault_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;

    // Ramp up from idle: 3,6,9,10 on successive ticks, then RUN.
    en = 1'b1; duty_req = 8'd10;
    run("ramp_up", 20);
    check_eq("ramp_up.final_duty", int'(duty_out), 10);
    check_eq("ramp_up.run_state", int'(state_out), 2);
    check_eq("ramp_up.busy", int'(busy), 0);
    check_eq("ramp_up.pwm", int'(pwm_en), 1);

    // Disable: ramp down 7,4,1,0 then IDLE.
    en = 1'b0;
    run("ramp_down", 20);
    check_eq("ramp_down.state", int'(state_out), 0);
    check_eq("ramp_down.pwm", int'(pwm_en), 0);
    check_eq("ramp_down.duty", int'(duty_out), 0);

    // Reversal: ramp to 0, dead time, direction flips, ramp back to 10.
    en = 1'b1;
    run("rev_up", 20);
    dir_req = 1'b1;
    run("rev_down", 21);
    check_eq("rev.dead_state", int'(state_out), 3);
    check_eq("rev.dead_pwm", int'(pwm_en), 0);
    check_eq("rev.dead_dir_held", int'(dir_out), 0);
    run("rev_back", 40);
    check_eq("rev.dir_out", int'(dir_out), 1);
    check_eq("rev.duty", int'(duty_out), 10);
    check_eq("rev.state", int'(state_out), 2);

    // Fault mid-ramp, clear attempts with en high then low.
    duty_req = 8'd40;
    run("pre_fault", 6);
    fault = 1'b1;
    cycle("fault");
    check_eq("fault.state", int'(state_out), 4);
    check_eq("fault.duty", int'(duty_out), 0);
    check_eq("fault.pwm", int'(pwm_en), 0);
    check_eq("fault.dir_kept", int'(dir_out), 1);
    fault = 1'b0; fault_clr = 1'b1;
    cycle("fault_clr_en");
    check_eq("fault.clr_ignored", int'(state_out), 4);
    fault_clr = 1'b0;
    cycle("fault_hold");
    en = 1'b0; fault_clr = 1'b1;
    cycle("fault_clr");
    check_eq("fault.cleared", int'(state_out), 0);
    fault_clr = 1'b0;

    // Full-scale ramp saturates at 255, then retargets down to 250.
    en = 1'b1; duty_req = 8'd255;
    run("sat_up", 350);
    check_eq("sat.top", int'(duty_out), 255);
    check_eq("sat.run", int'(state_out), 2);
    duty_req = 8'd250;
    run("sat_down", 20);
    check_eq("sat.down", int'(duty_out), 250);
    check_eq("sat.run2", int'(state_out), 2);

    // Asynchronous reset in the middle of a ramp.
    duty_req = 8'd100;
    run("pre_rst", 10);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomized operation against the model.
    en = 1'b0; dir_req = 1'b0; duty_req = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99, 0) < 3) en = ~en;
      if ($urandom_range(99, 0) < 2) dir_req = ~dir_req;
      if ($urandom_range(99, 0) < 5) begin
        case ($urandom_range(3, 0))
          0:       duty_req = 8'd0;
          1:       duty_req = 8'd255;
          default: duty_req = DUTY_W'($urandom_range(255, 0));
        endcase
      end
      fault     = ($urandom_range(199, 0) < 2);
      fault_clr = ($urandom_range(99, 0) < 10);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
